// File: rtl/name_sequence_generator_if.sv
//------------------------------------------------------------------------------
// Module      : name_sequence_generator_if
// Description : Control, handshake and letter-bus bundle for the name-sequence
//               transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface name_sequence_generator_if;
  logic       start;
  logic [3:0] repeat_cnt;
  logic [3:0] gap;
  logic       lower;
  logic       ready;
  logic [7:0] letter;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] char_idx;

  modport master (
    output start, repeat_cnt, gap, lower, ready,
    input  letter, valid, busy, done, char_idx
  );

  modport slave (
    input  start, repeat_cnt, gap, lower, ready,
    output letter, valid, busy, done, char_idx
  );
endinterface

`default_nettype wire

// File: rtl/name_sequence_generator.sv
//------------------------------------------------------------------------------
// Module      : name_sequence_generator
// Description : Streams a stored ASCII name one character per valid/ready
//               transfer, with repeat passes, lowercase option and idle gaps.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module name_sequence_generator #(
  parameter int                    NAME_LEN  = 9,
  parameter logic [8*NAME_LEN-1:0] NAME      = "RITUSHREE",
  parameter logic [7:0]            IDLE_CHAR = 8'h00
) (
  input  wire                         clk,
  input  wire                         rst,
  name_sequence_generator_if.slave    bus
);

  localparam logic [3:0] c_last_idx = 4'(NAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_letter;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_idx;
  logic [3:0] r_pass;
  logic [3:0] r_gap_cfg;
  logic [3:0] r_gap_cnt;
  logic       r_lower;

  // Character 0 lives in the most significant byte of NAME.
  function automatic logic [7:0] name_char(input logic [3:0] idx);
    logic [7:0] c;
    c = IDLE_CHAR;
    for (int i = 0; i < NAME_LEN; i++) begin
      if (idx == 4'(i)) c = NAME[8*(NAME_LEN-1-i) +: 8];
    end
    return c;
  endfunction

  function automatic logic [7:0] fold_case(input logic [7:0] c, input logic lo);
    if (lo && (c >= 8'h41) && (c <= 8'h5A)) return c + 8'h20;
    return c;
  endfunction

  logic       w_wrap;
  logic       w_final;
  logic [3:0] w_next_idx;
  logic [7:0] w_next_char;
  logic [7:0] w_cur_char;
  logic [7:0] w_first_char;

  assign w_wrap       = (r_idx == c_last_idx);
  assign w_final      = w_wrap && (r_pass == 4'd1);
  assign w_next_idx   = w_wrap ? 4'd0 : r_idx + 4'd1;
  assign w_next_char  = fold_case(name_char(w_next_idx), r_lower);
  assign w_cur_char   = fold_case(name_char(r_idx), r_lower);
  // The lowercase option is being latched this very cycle, so use the input.
  assign w_first_char = fold_case(name_char(4'd0), bus.lower);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_letter  <= IDLE_CHAR;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= 4'd0;
      r_pass    <= 4'd0;
      r_gap_cfg <= 4'd0;
      r_gap_cnt <= 4'd0;
      r_lower   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && (bus.repeat_cnt != 4'd0)) begin
            r_pass    <= bus.repeat_cnt;
            r_gap_cfg <= bus.gap;
            r_lower   <= bus.lower;
            r_idx     <= 4'd0;
            r_letter  <= w_first_char;
            r_valid   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.ready) begin
            r_idx <= w_next_idx;
            if (w_wrap) r_pass <= r_pass - 4'd1;
            if (w_final) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b0;
              r_letter <= IDLE_CHAR;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else if (r_gap_cfg == 4'd0) begin
              r_letter <= w_next_char;
            end else begin
              r_state   <= S_GAP;
              r_valid   <= 1'b0;
              r_letter  <= IDLE_CHAR;
              r_gap_cnt <= r_gap_cfg;
            end
          end
        end
        S_GAP: begin
          // Leaving on the edge where the count reaches 1 gives exactly gap idle cycles.
          if (r_gap_cnt <= 4'd1) begin
            r_gap_cnt <= 4'd0;
            r_state   <= S_SEND;
            r_valid   <= 1'b1;
            r_letter  <= w_cur_char;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.letter   = r_letter;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.char_idx = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_name_sequence_generator.sv
//------------------------------------------------------------------------------
// Module      : tb_name_sequence_generator
// Description : Scoreboard bench for name_sequence_generator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_name_sequence_generator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  name_sequence_generator_if bus();

  name_sequence_generator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] ch;
    logic [3:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] up_tab [9] = '{8'h52, 8'h49, 8'h54, 8'h55, 8'h53, 8'h48, 8'h52, 8'h45, 8'h45};
  logic [7:0] lo_tab [9] = '{8'h72, 8'h69, 8'h74, 8'h75, 8'h73, 8'h68, 8'h72, 8'h65, 8'h65};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: a transfer happens on the edge following a negedge with valid&ready.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (!rst) begin
        if (bus.valid && bus.ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_char", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("letter", 32'(bus.letter), 32'(e.ch));
            chk("char_idx", 32'(bus.char_idx), 32'(e.idx));
          end
        end
        if (bus.busy && !bus.valid) chk("gap_letter", 32'(bus.letter), 32'h00);
        if (bus.done) chk("done_pending", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic run_case(input logic [3:0] rep, input logic [3:0] gp, input logic low,
                          input int stall_at, input int restart_at, input int reset_at);
    int  busy_n, gap_n, zrun, stalled, n_chars;
    bit  seen_done, restarted, did_reset;
    logic [7:0] first;
    busy_n = 0; gap_n = 0; zrun = 0; stalled = 0;
    seen_done = 0; restarted = 0; did_reset = 0;
    n_chars = 9 * int'(rep);
    for (int p = 0; p < int'(rep); p++)
      for (int i = 0; i < 9; i++) begin
        exp_t e;
        e.ch  = low ? lo_tab[i] : up_tab[i];
        e.idx = 4'(i);
        exp_q.push_back(e);
      end
    first = low ? lo_tab[0] : up_tab[0];

    @(posedge clk); #1;
    bus.start = 1'b1; bus.repeat_cnt = rep; bus.gap = gp; bus.lower = low; bus.ready = 1'b1;
    @(posedge clk); #1;
    // Scramble configuration to show it was latched at start.
    bus.start = 1'b0; bus.repeat_cnt = 4'd0; bus.gap = 4'hF; bus.lower = ~low;
    chk("first_valid", 32'(bus.valid), 32'd1);
    chk("first_letter", 32'(bus.letter), 32'(first));

    for (int c = 0; c < 1000; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus.start = 1'b0;
      if (bus.done) begin seen_done = 1; break; end
      if (bus.busy) busy_n++;
      if (bus.busy && !bus.valid) begin gap_n++; zrun++; end
      if (bus.valid) begin
        if (zrun != 0) chk("gap_len", 32'(zrun), 32'(gp));
        zrun = 0;
      end
      if (stall_at >= 0 && bus.valid && bus.char_idx == 4'(stall_at)) begin
        if (stalled > 0) begin
          chk("stall_letter", 32'(bus.letter), 32'(up_tab[stall_at]));
          chk("stall_idx", 32'(bus.char_idx), 32'(stall_at));
        end
        if (stalled < 3) begin bus.ready = 1'b0; stalled++; end
        else bus.ready = 1'b1;
      end else begin
        bus.ready = 1'b1;
      end
      if (restart_at >= 0 && !restarted && bus.valid && bus.char_idx == 4'(restart_at)) begin
        bus.start = 1'b1; bus.repeat_cnt = 4'd3; restarted = 1;
      end
      if (reset_at >= 0 && bus.valid && bus.char_idx == 4'(reset_at)) begin
        #3 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_letter", 32'(bus.letter), 32'h00);
        chk("rst_idx", 32'(bus.char_idx), 32'd0);
        did_reset = 1;
        break;
      end
    end

    if (did_reset) begin
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        chk("post_rst_quiet", {29'd0, bus.valid, bus.busy, bus.done}, 32'd0);
      end
    end else begin
      chk("done_seen", 32'(seen_done), 32'd1);
      chk("busy_at_done", 32'(bus.busy), 32'd0);
      chk("busy_cycles", 32'(busy_n), 32'(n_chars + (n_chars - 1) * int'(gp) + stalled));
      chk("gap_cycles", 32'(gap_n), 32'((n_chars - 1) * int'(gp)));
      // A start presented during the done cycle must be ignored.
      bus.start = 1'b1; bus.repeat_cnt = 4'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("done_width", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      chk("start_in_done_ignored", {30'd0, bus.valid, bus.busy}, 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.repeat_cnt = 4'd0; bus.gap = 4'd0; bus.lower = 1'b0; bus.ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("reset_state", {bus.letter, 1'b0, bus.valid, bus.busy, bus.done, bus.char_idx}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_case(4'd1, 4'd0, 1'b0, -1, -1, -1);
    run_case(4'd1, 4'd0, 1'b1, -1, -1, -1);
    run_case(4'd1, 4'd0, 1'b0,  2, -1, -1);
    run_case(4'd2, 4'd2, 1'b0, -1, -1, -1);

    // Start with zero passes is ignored.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.repeat_cnt = 4'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("zero_rep_idle", {30'd0, bus.valid, bus.busy}, 32'd0);
      @(posedge clk); #1;
    end

    run_case(4'd1, 4'd0, 1'b0, -1,  5, -1);
    run_case(4'd1, 4'd0, 1'b0, -1, -1,  4);
    run_case(4'd1, 4'd0, 1'b0, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/name_sequence_generator.md
Name: name_sequence_generator

Overview:
- Transmit side of the name-sequence path: emits a stored ASCII name one character per accepted transfer on an 8-bit letter bus.
- Downstream name-sequence detectors and stimulus paths consume this bus.
- Supports a valid/ready handshake, repeated passes, optional lowercase conversion and programmable idle gaps between characters.

Parameters:
- NAME, "RITUSHREE" (8*NAME_LEN-bit string), name to transmit; first character is the most significant byte.
- NAME_LEN, 9, number of characters in NAME (1..15).
- IDLE_CHAR, 8'h00, value driven on letter whenever valid=0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to begin transmission; honoured only in IDLE.
- repeat_cnt  input  4  number of full passes of NAME; sampled at accepted start.
- gap  input  4  idle cycles inserted after every accepted character except the last; sampled at accepted start.
- lower  input  1  1 = emit 'A'..'Z' as lowercase; sampled at accepted start.
- ready  input  1  downstream can accept the current letter.
- letter  output  8  current character (registered).
- valid  output  1  letter is valid (registered).
- busy  output  1  transmission in progress.
- done  output  1  one-cycle pulse after the final character is accepted.
- char_idx  output  4  index within NAME of the current character.

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed):
  - state=IDLE, letter=IDLE_CHAR, valid=0, busy=0, done=0, char_idx=0, pass counter=0, gap counter=0.
- FSM states are IDLE, SEND, GAP and DONE. All outputs are registered.
- IDLE:
  - start=1 and repeat_cnt!=0: latch repeat_cnt, gap and lower; set char_idx=0; go to SEND.
  - On the next edge: valid=1, busy=1, letter=NAME[0]. Latency from start to first valid is one cycle.
  - start with repeat_cnt=0 is ignored; the block stays in IDLE.
- SEND:
  - valid=1.
  - While ready=0: letter and char_idx are held stable.
  - Transfer occurs on a clock edge with valid&ready=1.
  - After a transfer, the next index is char_idx+1. If char_idx=NAME_LEN-1, the index wraps to 0 and the pass counter decrements.
  - Last character of the last pass transferred: go to DONE, valid=0, letter=IDLE_CHAR.
  - Otherwise, gap=0: stay in SEND with the next character on the following cycle (back-to-back, one character per cycle under ready=1).
  - Otherwise, gap!=0: go to GAP, valid=0, letter=IDLE_CHAR, gap counter=gap.
- GAP:
  - Gap counter decrements each cycle. After exactly `gap` cycles with valid=0, return to SEND presenting the next character.
  - The gap applies between passes as well as within a pass.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start during DONE is ignored.
  - A new start is accepted in the cycle after done.
- start while busy (SEND or GAP) is ignored. Configuration inputs are not re-sampled mid-stream.
- Lowercase conversion: when lower is latched and the character is in 8'h41..8'h5A, letter = char + 8'h20. All other bytes pass unchanged.
- Reset mid-stream: all outputs take reset values immediately, no done pulse is produced, and the next start begins at NAME[0].
- Total accepted characters per run = repeat_cnt*NAME_LEN. Maximum run is 15 passes.
- busy=1 from the cycle valid first rises until the cycle done asserts (exclusive).

Test Plan:
- Reset, then start, repeat_cnt=1, gap=0, lower=0, ready=1:
  - letter = 52,49,54,55,53,48,52,45,45 (hex) with valid=1 on 9 consecutive cycles, starting the cycle after start.
  - done pulses the cycle after 45; busy is high for exactly 9 cycles.
- Same stimulus with lower=1:
  - letter = 72,69,74,75,73,68,72,65,65 (hex).
- ready backpressure: ready=1, then ready=0 for 3 cycles while char_idx=2:
  - letter holds 8'h54 with valid=1 and char_idx=2 through the stall.
  - Sequence resumes with 8'h55 after ready returns; no characters are dropped or duplicated.
- repeat_cnt=2, gap=2, ready=1:
  - Each character is followed by 2 cycles of valid=0 and letter=8'h00, including between passes.
  - 18 characters are delivered in total; the second pass starts with 8'h52; done follows the 18th character with no trailing gap.
- Ignored starts:
  - start with repeat_cnt=0: no valid and no busy.
  - start pulsed at char_idx=5 during a run: the run completes unchanged with exactly 9 characters.
- Async reset mid-stream:
  - Assert rst between clock edges at char_idx=4: valid, busy and done are 0 and letter=8'h00 immediately, with no done pulse.
  - A following start emits 8'h52 first.
